// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The optional two's-complement overflow output is enabled with SUB_OVF_EN.
package serial_sub_pkg;

    // Controller states: wait for start, process one bit per clock, report result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Width of the bit counter that walks through WIDTH operand bits.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow out of this bit position.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B, LSB first, one bit per clock through a
// single full_subtractor cell and a borrow flip-flop, behind a start/ready/done
// handshake.
//
// Handshake: start is accepted only on a rising edge where ready=1 (IDLE).
// After acceptance a and b are don't-care. done is a one-cycle pulse in DONE,
// and diff/borrow_out (plus ovf when SUB_OVF_EN is defined) are valid during
// that pulse and hold until the next DONE. start while ready=0 is ignored.
//
// Define SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SUB_OVF_EN
    output logic             ovf,
`endif
    output state_e           dbg_state_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bo_q, bo_d;
`ifdef SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and datapath: capture on accept, shift one bit per SHIFT edge,
    // publish the result on the edge that processes the MSB.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;
`ifdef SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {cell_d, res_q[WIDTH-1:1]};
                br_d  = cell_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bo_d    = cell_bout;
`ifdef SUB_OVF_EN
                    // At the MSB step a_q[0]/b_q[0] are the captured operand MSBs.
                    ovf_d   = (a_q[0] != b_q[0]) && (cell_d != a_q[0]);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and result outputs.
    always_comb begin
        ready       = (state_q == IDLE);
        done        = (state_q == DONE);
        diff        = diff_q;
        borrow_out  = bo_q;
`ifdef SUB_OVF_EN
        ovf         = ovf_q;
`endif
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed cases, mid-operation disturbances
// and randomized operand pairs checked against an arithmetic reference model.
// Define SUB_OVF_EN to also check the overflow output.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W  = 4;
    localparam int EW = W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    state_e       dbg_state;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .done        (done),
        .diff        (diff),
        .borrow_out  (borrow_out),
`ifdef SUB_OVF_EN
        .ovf         (ovf),
`endif
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];   // {ovf, borrow, diff}
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [W-1:0] held_diff = '0;
    logic         held_bo   = 1'b0;
    int done_cyc  = 0;
    bit hold_junk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        int ua;
        int ub;
        int sa;
        int sb;
        int r;
        logic [W-1:0] dv;
        logic bo;
        logic ov;
        ua = int'(av);
        ub = int'(bv);
        bo = (ua < ub);
        dv = W'((ua - ub + (1 << W)) % (1 << W));
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        r  = sa - sb;
        ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return {ov, bo, dv};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge while the DUT should be idle.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        check("ready_before_start", ready, 1);
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back(model(av, bv));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Waits for done, checking latency, held outputs during SHIFT and the result.
    // Returns at the negedge after done, where the DUT should be idle again.
    task automatic wait_done(input string tag);
        int lat;
        logic [EW-1:0] e;
        lat = 0;
        e = '0;
        do begin
            @(negedge clk);
            lat++;
            if (hold_junk) begin
                start = 1'b1;
                a = W'(1);
                b = W'(1);
            end
            if (!done) begin
                check({tag, "_diff_held"}, diff, held_diff);
                check({tag, "_borrow_held"}, borrow_out, held_bo);
                check({tag, "_busy"}, ready, 0);
            end
        end while (!done && lat < 20);
        start = 1'b0;
        done_cyc = cyc;
        check({tag, "_latency"}, lat, W + 1);
        check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check({tag, "_diff"}, diff, e[W-1:0]);
        check({tag, "_borrow"}, borrow_out, e[W]);
`ifdef SUB_OVF_EN
        check({tag, "_ovf"}, ovf, e[W+1]);
`endif
        held_diff = e[W-1:0];
        held_bo   = e[W];
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_ready_after"}, ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        int first_done;
        int seen_done;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(4'd8, 4'd3);
        wait_done("d_8m3");
        issue(4'd3, 4'd5);
        wait_done("d_3m5");
        issue(4'd7, 4'd8);
        wait_done("d_7m8");

        // Back-to-back on the first ready cycle
        issue(4'd15, 4'd15);
        wait_done("b2b_first");
        first_done = done_cyc;
        issue(4'd0, 4'd0);
        wait_done("b2b_second");
        check("b2b_done_spacing", done_cyc - first_done, W + 2);

        // start held with junk operands during SHIFT is ignored
        issue(4'd8, 4'd3);
        hold_junk = 1'b1;
        wait_done("hold_start");
        hold_junk = 1'b0;
        check("hold_no_extra_accept", ready, 1);

        // Reset during SHIFT aborts the operation
        issue(4'd9, 4'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ready", ready, 1);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow_out, 0);
        check("midrst_done", done, 0);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        held_diff = '0;
        held_bo   = 1'b0;
        seen_done = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("midrst_no_done", seen_done, 0);
        check("midrst_idle", ready, 1);

        // Randomized operand pairs, sometimes with idle gaps
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 3);
            if (gap == 3) repeat ($urandom_range(1, 2)) @(negedge clk);
            issue(W'($urandom), W'($urandom));
            wait_done("rnd");
        end

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
